uart_pkt_rx: RTL
================

// Module: uart_pkt_rx
//
// PURPOSE
//  Frame controller that sequences uart_rx and its serial CRC tap. It parses the
//  byte stream as SOF, LEN, PAYLOAD[LEN], CRC8 and writes payload bytes into an
//  external packet buffer. It reports each frame as good (pkt_done) or bad
//  (pkt_err). It sits between uart_rx and the command/packet consumer.
//
// PARAMETERS
//  SOF_BYTE  8'hAA  start-of-frame marker; not covered by CRC
//  MAX_LEN   64     largest accepted LEN; LEN > MAX_LEN is an error
//  AW        6      buffer address width; requires 2**AW >= MAX_LEN
//  TIMEOUT   240    clk cycles allowed between bytes inside a frame (2 byte-times @12M/1M)
//
// PORTS
//  clk          in   1   system clock, 12 MHz
//  rst          in   1   reset, asynchronous, active-high
//  rx_data      in   8   uart_rx.data
//  rx_ready     in   1   uart_rx.ready, 1-cycle pulse per byte
//  rx_crc_din   in   1   uart_rx.crc_din, serial bit, LSB first
//  rx_crc_en    in   1   uart_rx.crc_en, bit strobe
//  buf_we       out  1   payload write strobe
//  buf_waddr    out  AW  payload index, 0..LEN-1
//  buf_wdata    out  8   payload byte
//  pkt_done     out  1   1-cycle pulse: frame received, CRC good
//  pkt_err      out  1   1-cycle pulse: frame dropped
//  pkt_errcode  out  2   01 = CRC mismatch, 10 = timeout, 11 = overlength; held until next pkt_err
//  pkt_len      out  8   LEN of the last good frame; held until next pkt_done
//  busy         out  1   high in any state other than IDLE
//
// BEHAVIOUR
//  - Reset (async) values: state IDLE; crc 8'h00; all outputs 0.
//  - Reset asserted mid-frame drops the frame silently, with no pkt_err.
//  - States and transitions, each on rx_ready:
//    IDLE:    rx_data==SOF_BYTE -> LEN; any other byte is ignored.
//    LEN:     LEN > MAX_LEN -> pkt_err(11), then IDLE.
//             LEN == 0 -> CRC. Otherwise latch len and clear idx -> PAYLOAD.
//    PAYLOAD: buf_we=1, buf_waddr=idx, buf_wdata=rx_data; idx++.
//             When idx==len-1 -> CRC.
//    CRC:     rx_data==crc -> pkt_done, pkt_len=len. Else pkt_err(01). Then IDLE.
//  - All outputs are registered. buf_we, pkt_done and pkt_err assert the cycle
//    after the qualifying rx_ready. Buffer contents are valid only after pkt_done.
//  - CRC-8, poly 0x07, init 0x00, no reflection, no xorout. Bits are fed in wire
//    order (LSB first). Update on rx_crc_en:
//    crc <= {crc[6:0],1'b0} ^ ((crc[7]^rx_crc_din) ? 8'h07 : 8'h00).
//  - CRC updates only in states LEN and PAYLOAD. In IDLE, crc is held at 0x00.
//  - CRC updates are frozen in state CRC. The CRC byte's bits arrive after
//    entering CRC, so the compare uses the LEN+payload value.
//  - Timeout counter: cleared on every rx_ready and while in IDLE; otherwise
//    increments. Reaching TIMEOUT -> pkt_err(10), then IDLE.
//  - If rx_ready and the timeout terminal count occur in the same cycle, rx_ready wins.
//  - A new SOF_BYTE arriving inside a frame is data; there is no resync.
//  - pkt_done and pkt_err never assert in the same cycle.
//  - No backpressure: buffer writes must be accepted every cycle.
//
// STRUCTURE
//  - uart_pkt_pkg:
//    - state enum {IDLE, LEN, PAYLOAD, CRC}
//    - errcode localparams ERR_CRC=2'b01, ERR_TIMEOUT=2'b10, ERR_OVERLEN=2'b11
//    - CRC8_POLY = 8'h07
//  - Sub-module crc8_serial holds the CRC register and bit update.
//    - Ports: clk, rst, clr, en, din, crc[7:0].
//    - Reused by the future uart_tx framer.
//
// TESTING
//  1. AA 00 00 -> pkt_done, pkt_len=0, no buf_we, busy falls 1 cycle after the CRC byte's ready.
//  2. AA 01 00 B6 -> one buf_we (addr 0, data 00), then pkt_done with pkt_len=1.
//  3. AA 01 00 B7 -> buf_we at addr 0, then pkt_err, errcode=01, no pkt_done.
//  4. 55 13 AA 41 (MAX_LEN=64, LEN=0x41) -> leading bytes ignored; pkt_err, errcode=11; no writes.
//  5. AA 03 11 then 300 idle cycles -> pkt_err, errcode=10, TIMEOUT cycles after the 0x11 ready.
//     A following AA 00 00 must then pass.
//  6. rst pulsed after AA 02 01 -> busy=0, no pkt_err. AA 00 00 afterwards -> pkt_done.
//     Also: rx_ready on the timeout terminal cycle -> byte accepted, no timeout.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet receiver and its CRC engine.
package uart_pkt_pkg;

    // Frame parser states.
    typedef enum logic [1:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CRC
    } state_e;

    // Error codes reported on pkt_errcode.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CRC     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERLEN = 2'b11;

    // CRC-8 generator polynomial x^8 + x^2 + x + 1.
    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One serial CRC-8 step: non-reflected register, bits fed in wire order.
    function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic din);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 register. Shared by the receive parser and the transmit framer.
module crc8_serial
    import uart_pkt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic [7:0] crc_d;
    logic [7:0] crc_q;

    // Next CRC value: clear has priority over a bit update.
    always_comb begin
        // NOTE: default first so every path assigns crc_d and no latch is inferred.
        crc_d = crc_q;
        if (clr) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = crc8_bit(crc_q, din);
        end
    end

    // CRC register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for every flop so all state updates together.
        if (rst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/uart_pkt_rx.sv
// UART frame receiver: parses SOF, LEN, PAYLOAD[LEN], CRC8 from the byte stream,
// writes payload bytes to an external buffer and flags each frame good or bad.
// AW must satisfy 2**AW >= MAX_LEN so every payload index is addressable.
module uart_pkt_rx
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE = 8'hAA,
    parameter int          MAX_LEN  = 64,
    parameter int          AW       = 6,
    parameter int          TIMEOUT  = 240
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_ready,
    input  logic          rx_crc_din,
    input  logic          rx_crc_en,
    output logic          buf_we,
    output logic [AW-1:0] buf_waddr,
    output logic [7:0]    buf_wdata,
    output logic          pkt_done,
    output logic          pkt_err,
    output logic [1:0]    pkt_errcode,
    output logic [7:0]    pkt_len,
    output logic          busy
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e        state_q,     state_d;
    logic [7:0]    len_q,       len_d;
    logic [AW-1:0] idx_q,       idx_d;
    logic [TW-1:0] tmo_q,       tmo_d;
    logic          buf_we_q,    buf_we_d;
    logic [AW-1:0] buf_waddr_q, buf_waddr_d;
    logic [7:0]    buf_wdata_q, buf_wdata_d;
    logic          pkt_done_q,  pkt_done_d;
    logic          pkt_err_q,   pkt_err_d;
    logic [1:0]    errcode_q,   errcode_d;
    logic [7:0]    pkt_len_q,   pkt_len_d;
    logic          busy_q,      busy_d;

    logic       crc_clr;
    logic       crc_en;
    logic [7:0] crc;

    // CRC covers LEN and payload only: held clear in IDLE, frozen while the CRC byte arrives.
    assign crc_clr = (state_q == IDLE);
    assign crc_en  = rx_crc_en && ((state_q == LEN) || (state_q == PAYLOAD));

    crc8_serial u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (rx_crc_din),
        .crc (crc)
    );

    // Frame parser next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        buf_we_d    = 1'b0;
        buf_waddr_d = buf_waddr_q;
        buf_wdata_d = buf_wdata_q;
        pkt_done_d  = 1'b0;
        pkt_err_d   = 1'b0;
        errcode_d   = errcode_q;
        pkt_len_d   = pkt_len_q;

        // Inter-byte timer restarts on every byte and sits at zero between frames.
        tmo_d = ((state_q == IDLE) || rx_ready) ? '0 : tmo_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (rx_ready && (rx_data == SOF_BYTE)) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (rx_ready) begin
                    if (rx_data > 8'(MAX_LEN)) begin
                        pkt_err_d = 1'b1;
                        errcode_d = ERR_OVERLEN;
                        state_d   = IDLE;
                    end else begin
                        len_d   = rx_data;
                        idx_d   = '0;
                        state_d = (rx_data == 8'd0) ? CRC : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_ready) begin
                    buf_we_d    = 1'b1;
                    buf_waddr_d = idx_q;
                    buf_wdata_d = rx_data;
                    idx_d       = idx_q + 1'b1;
                    if (8'(idx_q) == (len_q - 8'd1)) begin
                        state_d = CRC;
                    end
                end
            end
            CRC: begin
                if (rx_ready) begin
                    if (rx_data == crc) begin
                        pkt_done_d = 1'b1;
                        pkt_len_d  = len_q;
                    end else begin
                        pkt_err_d = 1'b1;
                        errcode_d = ERR_CRC;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timeout only fires when no byte arrives on the terminal cycle.
        if ((state_q != IDLE) && !rx_ready && (tmo_q == TMO_LAST)) begin
            state_d   = IDLE;
            pkt_err_d = 1'b1;
            errcode_d = ERR_TIMEOUT;
        end

        busy_d = (state_d != IDLE);
    end

    // Parser state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            buf_we_q    <= 1'b0;
            buf_waddr_q <= '0;
            buf_wdata_q <= '0;
            pkt_done_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
            errcode_q   <= ERR_NONE;
            pkt_len_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            buf_we_q    <= buf_we_d;
            buf_waddr_q <= buf_waddr_d;
            buf_wdata_q <= buf_wdata_d;
            pkt_done_q  <= pkt_done_d;
            pkt_err_q   <= pkt_err_d;
            errcode_q   <= errcode_d;
            pkt_len_q   <= pkt_len_d;
            busy_q      <= busy_d;
        end
    end

    assign buf_we      = buf_we_q;
    assign buf_waddr   = buf_waddr_q;
    assign buf_wdata   = buf_wdata_q;
    assign pkt_done    = pkt_done_q;
    assign pkt_err     = pkt_err_q;
    assign pkt_errcode = errcode_q;
    assign pkt_len     = pkt_len_q;
    assign busy        = busy_q;

endmodule
